reg_file: RTL and testbench

Dual-read, single-write 16-bit register file that sources the ALU's ReadData1/ReadData2 operands and sinks its WriteData/Overflow results. It sits between instruction decode and the ALU in the 16-bit datapath. A reset-driven clear sequencer zeroes every register before the datapath is released, and an overflow-suppression rule blocks writeback of overflowed arithmetic results.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/reg_clear_seq.sv | 47 ++++
 rtl/reg_file.sv | 113 +++++++++++
 tb/tb_reg_file.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the 16-bit datapath register file:
//   - default geometry (NUM_REGS / DATA_W / ADDR_W)
//   - clear-sequencer state encoding
//   - index of the hardwired-zero register
// Optional feature macro used by the register file: REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_ADDR_W   = 3;

   // Register 0 always reads as zero and never takes a write.
   localparam int ZERO_REG = 0;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage

// File: rtl/reg_clear_seq.sv
// ---------------------------------------------------------------------------
// reg_clear_seq
// Reset-driven clear sequencer. After rst drops it walks a counter over every
// register index, issuing one clear write per cycle, then releases the
// datapath.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (restarts the sequence)
//   busy        high while clearing; datapath must stall
//   clear_en    clear write strobe for this cycle
//   clear_addr  register index being cleared this cycle
// ---------------------------------------------------------------------------
module reg_clear_seq
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              clear_en,
   output logic [ADDR_W-1:0] clear_addr
);

   state_e            state_reg;
   logic [ADDR_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_CLEAR;
         cnt_reg   <= '0;
      end else if (state_reg == ST_CLEAR) begin
         cnt_reg <= cnt_reg + ADDR_W'(1);
         // The last index is cleared on the same edge that releases the datapath.
         if (cnt_reg == ADDR_W'(NUM_REGS - 1)) begin
            state_reg <= ST_READY;
         end
      end
   end

   assign busy       = (state_reg == ST_CLEAR);
   // The array is left alone on a reset edge; clearing starts on the next one.
   assign clear_en   = (state_reg == ST_CLEAR) && !rst;
   assign clear_addr = cnt_reg;

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Dual-read, single-write register file between decode and the ALU.
// Register 0 is hardwired zero. Writes flagged with ALU overflow are dropped
// and latch a sticky OvfFlag. A clear sequencer zeroes the array after reset.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ReadReg1/ReadReg2    read addresses
//   ReadData1/ReadData2  combinational read data (0 while Busy)
//   WriteReg/WriteData   write address / data from the ALU
//   RegWrite, Overflow   write enable, ALU overflow for WriteData
//   Busy                 clear in progress
//   OvfFlag              sticky: a write was suppressed by overflow
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding of
// WriteData onto a read port addressing the register being written.
// ---------------------------------------------------------------------------
module reg_file
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   input  logic              Overflow,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              Busy,
   output logic              OvfFlag
);

   logic [DATA_W-1:0] reg_mem_reg [NUM_REGS];
   logic              ovf_flag_reg;

   logic              busy;
   logic              clear_en;
   logic [ADDR_W-1:0] clear_addr;

   logic              wr_req;
   logic              wr_en;

   reg_clear_seq #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .busy       (busy),
      .clear_en   (clear_en),
      .clear_addr (clear_addr)
   );

   // A legal write: ready, enabled, not overflowed, not aimed at r0.
   assign wr_req = !busy && RegWrite && !Overflow && (WriteReg != ADDR_W'(ZERO_REG));
   // A reset edge drops whatever write is in flight.
   assign wr_en  = wr_req && !rst;

   always_ff @(posedge clk) begin
      if (clear_en) begin
         reg_mem_reg[clear_addr] <= '0;
      end else if (wr_en) begin
         reg_mem_reg[WriteReg] <= WriteData;
      end
   end

   // Overflow only counts when a write is actually attempted in READY;
   // r0 as target still sets the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_flag_reg <= 1'b0;
      end else if (!busy && RegWrite && Overflow) begin
         ovf_flag_reg <= 1'b1;
      end
   end

   // Read ports: identical muxes, one per port.
   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];

   assign rd_addr[0] = ReadReg1;
   assign rd_addr[1] = ReadReg2;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
         always_comb begin
            rd_data[gi] = '0;
            if (!busy && (rd_addr[gi] != ADDR_W'(ZERO_REG))) begin
`ifdef REGFILE_BYPASS_EN
               if (wr_req && (WriteReg == rd_addr[gi])) begin
                  rd_data[gi] = WriteData;
               end else begin
                  rd_data[gi] = reg_mem_reg[rd_addr[gi]];
               end
`else
               rd_data[gi] = reg_mem_reg[rd_addr[gi]];
`endif
            end
         end
      end
   endgenerate

   assign ReadData1 = rd_data[0];
   assign ReadData2 = rd_data[1];
   assign Busy      = busy;
   assign OvfFlag   = ovf_flag_reg;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Drives reg_file with directed scenarios followed by randomized traffic and
// compares every cycle's outputs against a behavioural model of the register
// file (array of values, a clear-progress count and a sticky overflow bit).
// ---------------------------------------------------------------------------
module tb_reg_file;

   localparam int NR = 8;
   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] ReadReg1, ReadReg2, WriteReg;
   logic [DW-1:0] WriteData;
   logic          RegWrite, Overflow;
   logic [DW-1:0] ReadData1, ReadData2;
   logic          Busy, OvfFlag;

   always #5 clk = ~clk;

   reg_file #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .Overflow  (Overflow),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .Busy      (Busy),
      .OvfFlag   (OvfFlag)
   );

   // Reference model
   logic [DW-1:0] model_regs [NR];
   int            cycles_since_rst;   // edges with rst=0 since the last reset
   logic          model_ovf;

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s txn=%0d observed=%h expected=%h", tag, txn, obs, exp);
      end
   endtask

   function automatic logic model_busy();
      return cycles_since_rst < NR;
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (model_busy() || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (RegWrite && !Overflow && WriteReg != 0 && WriteReg == a) return WriteData;
`endif
      return model_regs[a];
   endfunction

   // One transaction: apply inputs, check at negedge, advance model at posedge.
   task automatic cycle(input logic r, input logic rw, input logic [AW-1:0] wr,
                        input logic [DW-1:0] wd, input logic ov,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      rst = r; RegWrite = rw; WriteReg = wr; WriteData = wd; Overflow = ov;
      ReadReg1 = r1; ReadReg2 = r2;
      @(negedge clk);
      $display("txn %0d rst=%0b we=%0b wr=%0d wd=%h ov=%0b rr=%0d/%0d rd=%h/%h busy=%0b ovf=%0b",
               txn, r, rw, wr, wd, ov, r1, r2, ReadData1, ReadData2, Busy, OvfFlag);
      check_val("busy",  {15'd0, Busy},    {15'd0, model_busy()});
      check_val("ovf",   {15'd0, OvfFlag}, {15'd0, model_ovf});
      check_val("rdata1", ReadData1, model_read(r1));
      check_val("rdata2", ReadData2, model_read(r2));
      @(posedge clk);
      if (r) begin
         cycles_since_rst = 0;
         model_ovf = 1'b0;
      end else if (model_busy()) begin
         cycles_since_rst++;
         // Once the clear completes, every register holds zero.
         if (!model_busy()) for (int i = 0; i < NR; i++) model_regs[i] = '0;
      end else if (rw) begin
         if (ov) model_ovf = 1'b1;
         else if (wr != 0) model_regs[wr] = wd;
      end
      txn++;
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, r1, r2);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) model_regs[i] = '0;
      cycles_since_rst = 0;
      model_ovf = 1'b0;
      // Initial reset edge: DUT state is unknown before it, so no checks yet.
      rst = 1'b1; RegWrite = 1'b0; Overflow = 1'b0; WriteReg = '0;
      WriteData = '0; ReadReg1 = '0; ReadReg2 = '0;
      @(posedge clk); #1;

      // Reset state, held for one more cycle.
      cycle(1'b1, 1'b0, '0, '0, 1'b0, 3'd1, 3'd7);

      // Clear sequence with a write attempt to r2 on the third clear cycle.
      for (int i = 0; i < NR; i++) begin
         if (i == 2) cycle(1'b0, 1'b1, 3'd2, 16'h5555, 1'b0, 3'd2, 3'd2);
         else        idle(3'd2, 3'd1);
      end
      idle(3'd2, 3'd2);

      // Preload r1..r7 with 0xFFFF, then pulse reset and clear again.
      for (int i = 1; i < NR; i++) cycle(1'b0, 1'b1, AW'(i), 16'hFFFF, 1'b0, AW'(i), 3'd1);
      for (int i = 1; i < NR; i++) idle(AW'(i), AW'(NR - i));
      cycle(1'b1, 1'b0, '0, '0, 1'b0, 3'd1, 3'd2);
      for (int i = 0; i < NR; i++) idle(AW'(i), 3'd7);
      for (int i = 0; i < NR; i++) idle(AW'(i), AW'(NR - 1 - i));

      // Basic write/read on r3.
      cycle(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd3, 3'd3);
      idle(3'd3, 3'd3);

      // r0 hardwire.
      cycle(1'b0, 1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 3'd0);
      idle(3'd0, 3'd0);

      // Overflow suppression on r5, sticky flag through 10 idle cycles.
      cycle(1'b0, 1'b1, 3'd5, 16'h00AA, 1'b0, 3'd5, 3'd0);
      cycle(1'b0, 1'b1, 3'd5, 16'h8000, 1'b1, 3'd5, 3'd5);
      for (int i = 0; i < 10; i++) idle(3'd5, 3'd5);

      // Write r4 while reading it (forwarding visible only with bypass).
      cycle(1'b0, 1'b1, 3'd4, 16'h0F0F, 1'b0, 3'd4, 3'd4);
      idle(3'd4, 3'd3);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(63) == 0),
               ($urandom_range(1) == 1),
               AW'($urandom_range(NR - 1)),
               DW'($urandom),
               ($urandom_range(7) == 0),
               AW'($urandom_range(NR - 1)),
               AW'($urandom_range(NR - 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
